// File: rtl/memaccess.sv
// ----------------------------------------------------------------------------
// memaccess : LC-3 memory-access stage.
// Runs LD/LDR, LDI, ST/STR and STI transactions against a synchronous data
// memory whose read data appears RD_LATENCY cycles after the read strobe.
// Indirect forms first fetch a pointer and then use it as the final address.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle request, honoured only when not busy
//   M_Control     : 0=LD/LDR 1=LDI 2=ST/STR 3=STI
//   M_addr        : effective address from execute
//   M_data        : store value
//   dmem_dout     : data-memory read data
//   dmem_addr     : data-memory address (holds between strobes)
//   dmem_din      : data-memory write data (holds between strobes)
//   dmem_rd       : one-cycle read strobe
//   dmem_we       : one-cycle write strobe
//   memout        : last loaded value, to writeback
//   busy          : transaction in flight
//   mem_done      : one-cycle completion pulse
// All outputs are registered.
// ----------------------------------------------------------------------------
module memaccess #(
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        M_Control,
   input  logic [DATA_W-1:0] M_addr,
   input  logic [DATA_W-1:0] M_data,
   input  logic [DATA_W-1:0] dmem_dout,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_din,
   output logic              dmem_rd,
   output logic              dmem_we,
   output logic [DATA_W-1:0] memout,
   output logic              busy,
   output logic              mem_done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_PTR  = 3'd1,
      RD_DATA = 3'd2,
      WR      = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [1:0] CTRL_LD  = 2'd0;
   localparam logic [1:0] CTRL_LDI = 2'd1;
   localparam logic [1:0] CTRL_ST  = 2'd2;
   localparam logic [1:0] CTRL_STI = 2'd3;
   localparam logic [2:0] LAT_C    = 3'(RD_LATENCY);

   state_t            state_r, state_s;
   logic [2:0]        cnt_r, cnt_s;
   logic [1:0]        ctrl_r, ctrl_s;
   logic [DATA_W-1:0] data_r, data_s;
   logic [DATA_W-1:0] addr_s, din_s, memout_s;
   logic              rd_s, we_s, busy_s, done_s;

   // DONE behaves like IDLE for accepting a new request
   logic accept_s;
   assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

   // State and datapath register; reset aborts any transaction at once
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 3'd0;
         ctrl_r    <= 2'd0;
         data_r    <= '0;
         dmem_addr <= '0;
         dmem_din  <= '0;
         dmem_rd   <= 1'b0;
         dmem_we   <= 1'b0;
         memout    <= '0;
         busy      <= 1'b0;
         mem_done  <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         ctrl_r    <= ctrl_s;
         data_r    <= data_s;
         dmem_addr <= addr_s;
         dmem_din  <= din_s;
         dmem_rd   <= rd_s;
         dmem_we   <= we_s;
         memout    <= memout_s;
         busy      <= busy_s;
         mem_done  <= done_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               case (M_Control)
                  CTRL_LD:  state_s = RD_DATA;
                  CTRL_LDI: state_s = RD_PTR;
                  CTRL_ST:  state_s = WR;
                  CTRL_STI: state_s = RD_PTR;
                  default:  state_s = IDLE;
               endcase
            end else begin
               state_s = IDLE;
            end
         end
         RD_PTR: begin
            if (cnt_r == 3'd0) begin
               state_s = (ctrl_r == CTRL_LDI) ? RD_DATA : WR;
            end else begin
               state_s = RD_PTR;
            end
         end
         RD_DATA: begin
            if (cnt_r == 3'd0) begin
               state_s = DONE;
            end else begin
               state_s = RD_DATA;
            end
         end
         WR:      state_s = DONE;
         default: state_s = IDLE;
      endcase
   end

   // Next values of the registered outputs and latched request fields
   always_comb begin
      cnt_s    = cnt_r;
      ctrl_s   = ctrl_r;
      data_s   = data_r;
      addr_s   = dmem_addr;
      din_s    = dmem_din;
      memout_s = memout;
      rd_s     = 1'b0;
      we_s     = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               ctrl_s = M_Control;
               data_s = M_data;
               addr_s = M_addr;
               if (M_Control == CTRL_ST) begin
                  we_s  = 1'b1;
                  din_s = M_data;
               end else begin
                  rd_s  = 1'b1;
                  cnt_s = LAT_C;
               end
            end else begin
               cnt_s = 3'd0;
            end
         end
         RD_PTR: begin
            if (cnt_r == 3'd0) begin
               // captured word is the pointer for the second access
               addr_s = dmem_dout;
               if (ctrl_r == CTRL_LDI) begin
                  rd_s  = 1'b1;
                  cnt_s = LAT_C;
               end else begin
                  we_s  = 1'b1;
                  din_s = data_r;
               end
            end else begin
               cnt_s = cnt_r - 3'd1;
            end
         end
         RD_DATA: begin
            if (cnt_r == 3'd0) begin
               memout_s = dmem_dout;
            end else begin
               cnt_s = cnt_r - 3'd1;
            end
         end
         WR: begin
            cnt_s = 3'd0;
         end
         default: begin
            cnt_s = 3'd0;
         end
      endcase
   end

   // Status flags follow the state being entered
   always_comb begin
      done_s = (state_s == DONE);
      busy_s = (state_s != IDLE) && (state_s != DONE);
   end

endmodule

// File: tb/tb_memaccess.sv
// ----------------------------------------------------------------------------
// tb_memaccess : directed bench for memaccess. Two instances, one with read
// latency 1 and one with read latency 3, each attached to its own behavioural
// data memory. Cycle 0 is the cycle in which start is held high.
// ----------------------------------------------------------------------------
module tb_memaccess;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // latency-1 instance signals
   logic        rst1, start1, rd1, we1, busy1, done1;
   logic [1:0]  ctrl1;
   logic [15:0] maddr1, mdata1, dout1, addr1, din1, memout1;
   // latency-3 instance signals
   logic        rst3, start3, rd3, we3, busy3, done3;
   logic [1:0]  ctrl3;
   logic [15:0] maddr3, mdata3, dout3, addr3, din3, memout3;

   logic [15:0] mem1 [0:65535];
   logic [15:0] mem3 [0:65535];
   logic [15:0] p1, p3_0, p3_1, p3_2;
   int rd1_cnt = 0, done1_cnt = 0, rd3_cnt = 0, done3_cnt = 0;
   int snap;

   memaccess #(.DATA_W(16), .RD_LATENCY(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .M_Control(ctrl1),
      .M_addr(maddr1), .M_data(mdata1), .dmem_dout(dout1),
      .dmem_addr(addr1), .dmem_din(din1), .dmem_rd(rd1), .dmem_we(we1),
      .memout(memout1), .busy(busy1), .mem_done(done1));

   memaccess #(.DATA_W(16), .RD_LATENCY(3)) u3 (
      .clk(clk), .rst(rst3), .start(start3), .M_Control(ctrl3),
      .M_addr(maddr3), .M_data(mdata3), .dmem_dout(dout3),
      .dmem_addr(addr3), .dmem_din(din3), .dmem_rd(rd3), .dmem_we(we3),
      .memout(memout3), .busy(busy3), .mem_done(done3));

   // behavioural memories: read data valid RD_LATENCY cycles after the strobe
   always @(posedge clk) begin
      if (we1) mem1[addr1] = din1;
      if (we3) mem3[addr3] = din3;
      p1   <= rd1 ? mem1[addr1] : 16'h0000;
      p3_0 <= rd3 ? mem3[addr3] : 16'h0000;
      p3_1 <= p3_0;
      p3_2 <= p3_1;
      if (rd1)   rd1_cnt   <= rd1_cnt + 1;
      if (done1) done1_cnt <= done1_cnt + 1;
      if (rd3)   rd3_cnt   <= rd3_cnt + 1;
      if (done3) done3_cnt <= done3_cnt + 1;
   end
   assign dout1 = p1;
   assign dout3 = p3_2;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst1 = 1'b1; start1 = 1'b0; ctrl1 = 2'd0; maddr1 = 16'h0; mdata1 = 16'h0;
      rst3 = 1'b1; start3 = 1'b0; ctrl3 = 2'd0; maddr3 = 16'h0; mdata3 = 16'h0;
      mem1[16'h3000] = 16'hBEEF;
      mem1[16'h3001] = 16'h4000;
      mem1[16'h4000] = 16'h1234;
      mem1[16'h3003] = 16'h5000;
      mem3[16'h3004] = 16'hFFFF;
      mem3[16'hFFFF] = 16'h8001;
      cyc(3);
      chk("rst_rd", {15'd0, rd1}, 16'h0000);
      chk("rst_we", {15'd0, we1}, 16'h0000);
      chk("rst_busy", {15'd0, busy1}, 16'h0000);
      chk("rst_done", {15'd0, done1}, 16'h0000);
      chk("rst_memout", memout1, 16'h0000);
      chk("rst_addr", addr1, 16'h0000);
      rst1 = 1'b0; rst3 = 1'b0;
      cyc(1);

      // T1: LD, L=1
      start1 = 1'b1; ctrl1 = 2'd0; maddr1 = 16'h3000;
      cyc(1); start1 = 1'b0; maddr1 = 16'h0BAD;
      chk("t1_rd_c1", {15'd0, rd1}, 16'h0001);
      chk("t1_addr_c1", addr1, 16'h3000);
      chk("t1_busy_c1", {15'd0, busy1}, 16'h0001);
      cyc(1);
      chk("t1_rd_c2", {15'd0, rd1}, 16'h0000);
      chk("t1_done_c2", {15'd0, done1}, 16'h0000);
      cyc(1);
      chk("t1_done_c3", {15'd0, done1}, 16'h0001);
      chk("t1_memout_c3", memout1, 16'hBEEF);
      chk("t1_busy_c3", {15'd0, busy1}, 16'h0000);
      cyc(1);
      chk("t1_done_c4", {15'd0, done1}, 16'h0000);
      chk("t1_addr_hold", addr1, 16'h3000);

      // T2: LDI, L=1
      start1 = 1'b1; ctrl1 = 2'd1; maddr1 = 16'h3001;
      cyc(1); start1 = 1'b0;
      chk("t2_rd_c1", {15'd0, rd1}, 16'h0001);
      chk("t2_addr_c1", addr1, 16'h3001);
      cyc(1);
      chk("t2_rd_c2", {15'd0, rd1}, 16'h0000);
      cyc(1);
      chk("t2_rd_c3", {15'd0, rd1}, 16'h0001);
      chk("t2_addr_c3", addr1, 16'h4000);
      cyc(1);
      chk("t2_done_c4", {15'd0, done1}, 16'h0000);
      cyc(1);
      chk("t2_done_c5", {15'd0, done1}, 16'h0001);
      chk("t2_memout_c5", memout1, 16'h1234);
      cyc(1);

      // T3: ST then STI
      start1 = 1'b1; ctrl1 = 2'd2; maddr1 = 16'h3002; mdata1 = 16'h5A5A;
      cyc(1); start1 = 1'b0; mdata1 = 16'h0000;
      chk("t3_we_c1", {15'd0, we1}, 16'h0001);
      chk("t3_rd_c1", {15'd0, rd1}, 16'h0000);
      chk("t3_addr_c1", addr1, 16'h3002);
      chk("t3_din_c1", din1, 16'h5A5A);
      cyc(1);
      chk("t3_done_c2", {15'd0, done1}, 16'h0001);
      chk("t3_we_c2", {15'd0, we1}, 16'h0000);
      chk("t3_memout_st", memout1, 16'h1234);
      chk("t3_mem_st", mem1[16'h3002], 16'h5A5A);
      cyc(1);
      start1 = 1'b1; ctrl1 = 2'd3; maddr1 = 16'h3003; mdata1 = 16'h00FF;
      cyc(1); start1 = 1'b0; mdata1 = 16'hFFFF; maddr1 = 16'h1111;
      chk("t3_sti_rd_c1", {15'd0, rd1}, 16'h0001);
      chk("t3_sti_addr_c1", addr1, 16'h3003);
      cyc(2);
      chk("t3_sti_we_c3", {15'd0, we1}, 16'h0001);
      chk("t3_sti_addr_c3", addr1, 16'h5000);
      chk("t3_sti_din_c3", din1, 16'h00FF);
      cyc(1);
      chk("t3_sti_done_c4", {15'd0, done1}, 16'h0001);
      chk("t3_sti_memout", memout1, 16'h1234);
      chk("t3_sti_mem", mem1[16'h5000], 16'h00FF);
      cyc(1);

      // T4: LDI on the L=3 instance through pointer 0xFFFF
      snap = rd3_cnt;
      start3 = 1'b1; ctrl3 = 2'd1; maddr3 = 16'h3004;
      cyc(1); start3 = 1'b0;
      chk("t4_rd_c1", {15'd0, rd3}, 16'h0001);
      chk("t4_addr_c1", addr3, 16'h3004);
      cyc(3);
      // c4: request while busy must be dropped
      start3 = 1'b1; ctrl3 = 2'd0; maddr3 = 16'h2222;
      chk("t4_busy_c4", {15'd0, busy3}, 16'h0001);
      cyc(1); start3 = 1'b0;
      chk("t4_rd_c5", {15'd0, rd3}, 16'h0001);
      chk("t4_addr_c5", addr3, 16'hFFFF);
      cyc(3);
      chk("t4_done_c8", {15'd0, done3}, 16'h0000);
      cyc(1);
      chk("t4_done_c9", {15'd0, done3}, 16'h0001);
      chk("t4_memout_c9", memout3, 16'h8001);
      cyc(1);
      chk("t4_done_c10", {15'd0, done3}, 16'h0000);
      chk("t4_busy_c10", {15'd0, busy3}, 16'h0000);
      chk("t4_rd_count", 16'(rd3_cnt - snap), 16'd2);
      chk("t4_done_count", 16'(done3_cnt), 16'd1);

      // T5: reset in cycle 2 of an LDI
      snap = rd1_cnt;
      start1 = 1'b1; ctrl1 = 2'd1; maddr1 = 16'h3001;
      cyc(1); start1 = 1'b0;
      cyc(1); rst1 = 1'b1;
      cyc(1); rst1 = 1'b0;
      chk("t5_rd_c3", {15'd0, rd1}, 16'h0000);
      chk("t5_memout_c3", memout1, 16'h0000);
      chk("t5_busy_c3", {15'd0, busy1}, 16'h0000);
      cyc(2);
      chk("t5_rd_count", 16'(rd1_cnt - snap), 16'd1);
      start1 = 1'b1; ctrl1 = 2'd0; maddr1 = 16'h3000;
      cyc(1); start1 = 1'b0;
      chk("t5_ld_rd_c1", {15'd0, rd1}, 16'h0001);
      cyc(2);
      chk("t5_ld_done_c3", {15'd0, done1}, 16'h0001);
      chk("t5_ld_memout", memout1, 16'hBEEF);
      cyc(1);

      // T6: back-to-back LD accepted in the done cycle
      snap = done1_cnt;
      start1 = 1'b1; ctrl1 = 2'd0; maddr1 = 16'h3000;
      cyc(1); start1 = 1'b0;
      cyc(2);
      chk("t6_done_a", {15'd0, done1}, 16'h0001);
      chk("t6_memout_a", memout1, 16'hBEEF);
      start1 = 1'b1; ctrl1 = 2'd0; maddr1 = 16'h4000;
      cyc(1); start1 = 1'b0;
      chk("t6_rd_b", {15'd0, rd1}, 16'h0001);
      chk("t6_addr_b", addr1, 16'h4000);
      chk("t6_done_gap", {15'd0, done1}, 16'h0000);
      cyc(2);
      chk("t6_done_b", {15'd0, done1}, 16'h0001);
      chk("t6_memout_b", memout1, 16'h1234);
      cyc(2);
      chk("t6_done_count", 16'(done1_cnt - snap), 16'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
